// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Timed memory-side slave for the core's load/store port. Accepts one
//   word-wide request (read, or byte-masked write) over a valid/ready
//   handshake. The response appears LATENCY edges after the request is
//   accepted and is held until the core takes it. Only one transaction is
//   outstanding at a time.
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_req_valid    request present
//   o_req_ready    responder can accept a request
//   i_req_we       1 = write, 0 = read
//   i_req_addr     byte address (bits [1:0] ignored)
//   i_req_wdata    lane-aligned write data
//   i_req_mask     byte-lane write enables
//   o_rsp_valid    response present
//   i_rsp_ready    core accepts response
//   o_rsp_rdata    read data (0 for writes and errors)
//   o_rsp_err      address out of range
//
// States
//   S_IDLE | ready for a request
//   S_WAIT | request latched, counting down the access latency
//   S_RESP | response held until the core accepts it
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_mask;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [31:0]   w_word;
    logic [AW-1:0] w_idx;
    logic          w_in_range;
    logic          w_access;
    logic          w_commit;

    // Unsigned subtract: an address below BASE_ADDR wraps to a huge word
    // offset, and the explicit >= compare rejects it regardless.
    assign w_word     = (r_addr - BASE_ADDR) >> 2;
    assign w_idx      = w_word[AW-1:0];
    assign w_in_range = (r_addr >= BASE_ADDR) && (w_word < 32'(DEPTH_WORDS));
    assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_commit   = w_access && r_we && w_in_range;

    // Array kept out of the reset domain so contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_mask      <= 4'd0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (i_req_valid && r_req_ready) begin
                        r_we        <= i_req_we;
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_mask      <= i_req_mask;
                        r_cnt       <= 4'(LATENCY - 1);
                        r_req_ready <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                        if (!w_in_range) begin
                            r_rsp_rdata <= 32'd0;
                            r_rsp_err   <= 1'b1;
                        end else if (r_we) begin
                            r_rsp_rdata <= 32'd0;
                            r_rsp_err   <= 1'b0;
                        end else begin
                            r_rsp_rdata <= r_mem[w_idx];
                            r_rsp_err   <= 1'b0;
                        end
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder. Two instances share stimulus: dut_a
//   with LATENCY=2 and dut_b with LATENCY=1; 'sel' routes the handshake to
//   one of them and selects which outputs are observed.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_mask;
    logic        rsp_ready;

    logic        a_req_ready, b_req_ready;
    logic        a_rsp_valid, b_rsp_valid;
    logic [31:0] a_rsp_rdata, b_rsp_rdata;
    logic        a_rsp_err,   b_rsp_err;

    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_err = 0;
    int g_lat = 2;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) dut_a (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_valid (req_valid & ~sel),
        .o_req_ready (a_req_ready),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_mask  (req_mask),
        .o_rsp_valid (a_rsp_valid),
        .i_rsp_ready (rsp_ready & ~sel),
        .o_rsp_rdata (a_rsp_rdata),
        .o_rsp_err   (a_rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) dut_b (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_valid (req_valid & sel),
        .o_req_ready (b_req_ready),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_mask  (req_mask),
        .o_rsp_valid (b_rsp_valid),
        .i_rsp_ready (rsp_ready & sel),
        .o_rsp_rdata (b_rsp_rdata),
        .o_rsp_err   (b_rsp_err)
    );

    assign req_ready = sel ? b_req_ready : a_req_ready;
    assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Present a request, wait (bounded) for acceptance, then drop valid and
    // scramble the request bus. Returns with time at accept edge + 1.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
        int k;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_mask  = mask;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 32) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 32) chk("accept_timeout", 32'(k), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'hFFFF_FFF0;
        req_wdata = 32'h5555_5555;
        req_mask  = 4'hF;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!rsp_valid && k < 32) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    // Full transaction: hold response for 'hold' cycles, check it stays
    // stable, then complete the handshake.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask,
                       input int hold, input logic [31:0] exp_rdata, input logic exp_err);
        int k;
        issue(we, addr, wdata, mask);
        wait_valid(k);
        chk({tag, "_lat"}, 32'(k), 32'(g_lat));
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
            chk({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rdy_next"}, 32'(req_ready), 32'd1);
    endtask

    // Accept a write, then reset while it is still counting down.
    task automatic rst_in_wait(input logic [31:0] addr, input logic [31:0] wdata);
        issue(1'b1, addr, wdata, 4'hF);
        reset = 1'b1;
        #1;
        chk("rstw_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rstw_rdy", 32'(req_ready), 32'd1);
        chk("rstw_valid_after", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset     = 1'b1;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_mask  = 4'd0;
        rsp_ready = 1'b0;

        #12;
        chk("rst_rdy",   32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err",   32'(rsp_err), 32'd0);
        #5 reset = 1'b0;
        @(posedge clk); #1;
        chk("rdy_after_rst", 32'(req_ready), 32'd1);

        txn("wr_full",  1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
        txn("rd_full",  1'b0, 32'h10, 32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0);
        txn("wr_lane1", 1'b1, 32'h10, 32'h0000AB00, 4'b0010, 0, 32'h0, 1'b0);
        txn("rd_lane1", 1'b0, 32'h13, 32'h0,        4'h0, 0, 32'hDEADABEF, 1'b0);
        txn("wr_mask0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 1'b0);
        txn("rd_mask0", 1'b0, 32'h10, 32'h0,        4'h0, 5, 32'hDEADABEF, 1'b0);

        txn("wr_w0",    1'b1, 32'h0,    32'hA5A5A5A5, 4'hF, 0, 32'h0, 1'b0);
        txn("rd_oor",   1'b0, 32'h1000, 32'h0,        4'h0, 0, 32'h0, 1'b1);
        txn("wr_oor",   1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1);
        txn("rd_w0",    1'b0, 32'h0,    32'h0,        4'h0, 0, 32'hA5A5A5A5, 1'b0);
        txn("wr_last",  1'b1, 32'hFFC,  32'h11223344, 4'hF, 0, 32'h0, 1'b0);
        txn("rd_last",  1'b0, 32'hFFC,  32'h0,        4'h0, 0, 32'h11223344, 1'b0);

        // Asynchronous reset while a read response is being held.
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_valid(k);
        chk("resp_pre_rst_rdata", rsp_rdata, 32'hDEADABEF);
        #2 reset = 1'b1;
        #1;
        chk("arst_rdy",   32'(req_ready), 32'd0);
        chk("arst_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rdata", rsp_rdata, 32'd0);
        chk("arst_err",   32'(rsp_err), 32'd0);
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("arst_rdy_after", 32'(req_ready), 32'd1);
        txn("rd_retained", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADABEF, 1'b0);

        txn("wr_20",   1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0);
        rst_in_wait(32'h20, 32'h12345678);
        txn("rd_20",   1'b0, 32'h20, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0);

        sel   = 1'b1;
        g_lat = 1;
        @(posedge clk); #1;
        txn("l1_wr_20", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0);
        rst_in_wait(32'h20, 32'h12345678);
        txn("l1_rd_20", 1'b0, 32'h20, 32'h0, 4'h0, 2, 32'hCAFEF00D, 1'b0);
        txn("l1_wr_b2", 1'b1, 32'h20, 32'h00770000, 4'b0100, 0, 32'h0, 1'b0);
        txn("l1_rd_b2", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'hCA77F00D, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
